// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_write_arbiter
// Brief  : Sole owner of the register-file write port. Merges pipeline
//          writeback (fixed priority) with buffered long-latency results and
//          keeps a per-register pending scoreboard for hazard detection.
// Rev    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    input  logic [4:0]              a_addr,
    input  logic [31:0]             a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [4:0]              b_addr,
    input  logic [31:0]             b_data,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_addr,
    output logic                    issue_ok,
    output logic                    WE,
    output logic [4:0]              W,
    output logic [31:0]             WD,
    output logic [31:0]             busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int                 c_PW       = $clog2(DEPTH);
    localparam logic [c_PW:0]      c_FULL     = (c_PW+1)'(DEPTH);
    localparam logic [c_PW:0]      c_CNT_ONE  = (c_PW+1)'(1);
    localparam logic [c_PW-1:0]    c_PTR_ONE  = c_PW'(1);
    localparam logic [CNT_W-1:0]   c_PEND_MAX = '1;
    localparam logic [CNT_W-1:0]   c_PEND_ONE = CNT_W'(1);

    logic [4:0]       r_fifo_addr [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW:0]    r_count;
    logic [CNT_W-1:0] r_pend [32];

    logic             w_ready;
    logic             w_sel_a;
    logic             w_pop;
    logic             w_push;
    logic [4:0]       w_head_addr;
    logic [31:0]      w_head_data;
    logic [31:0]      w_inc;
    logic [31:0]      w_dec;

    // Ready depends only on stored occupancy, never on this cycle's pop.
    assign w_ready     = (r_count != c_FULL);
    assign b_ready     = w_ready;
    assign w_sel_a     = a_valid && (a_addr != 5'd0);
    assign w_pop       = !w_sel_a && (r_count != '0);
    assign w_push      = b_valid && w_ready && (b_addr != 5'd0);
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign issue_ok    = (r_pend[issue_addr] != c_PEND_MAX);
    assign fifo_count  = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= b_addr;
            r_fifo_data[r_wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WE <= 1'b0;
            W  <= 5'd0;
            WD <= 32'd0;
        end else if (w_sel_a) begin
            WE <= 1'b1;
            W  <= a_addr;
            WD <= a_data;
        end else if (w_pop) begin
            WE <= 1'b1;
            W  <= w_head_addr;
            WD <= w_head_data;
        end else begin
            WE <= 1'b0;
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        busy  = '0;
        for (int r = 1; r < 32; r++) begin
            w_inc[r] = issue_valid && issue_ok && (issue_addr == 5'(r));
            w_dec[r] = w_pop && (w_head_addr == 5'(r));
            busy[r]  = (r_pend[r] != '0);
        end
    end

    // Entry 0 is only ever cleared; register 0 is never tracked.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) r_pend[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (w_inc[r] && !w_dec[r])
                    r_pend[r] <= r_pend[r] + c_PEND_ONE;
                else if (w_dec[r] && !w_inc[r] && (r_pend[r] != '0))
                    r_pend[r] <= r_pend[r] - c_PEND_ONE;
            end
        end
    end

endmodule
`default_nettype wire
